// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t : controller states (REQ issues a fetch, HOLD parks a
//                   fetched word while decode stalls, DRAIN swallows the
//                   response to a request made before a redirect)
//   ifid_t        : IF/ID record {valid, pc, instr} at default widths
//   PC_INC        : byte step between sequential fetches
//   NOP_INSTR     : instruction value held by IF/ID after reset or a bubble
package fetch_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 32;
    localparam int PC_INC      = 4;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic                   valid;
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register.
//   clk, reset_n          : clock, asynchronous active-low reset
//   load                  : capture {load_pc, load_instr} and mark valid
//   clear                 : return to the empty (bubble) value; beats load
//   (neither)             : hold
//   valid, pc, instr      : registered IF/ID contents
module ifid_reg #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               clear,
    input  logic [PC_W-1:0]    load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr
);
    import fetch_pkg::*;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= INSTR_W'(NOP_INSTR);
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= INSTR_W'(NOP_INSTR);
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch controller between the PC register and
// the IF/ID boundary.
//   clk, reset_n                   : clock, asynchronous active-low reset
//   current_pc                     : PC register value
//   next_pc, pc_write              : PC load value / enable (combinational)
//   stall_id                       : decode cannot accept; hold IF/ID
//   branch_taken, branch_target    : redirect pulse and target address
//   imem_req, imem_addr            : fetch request / address (= current_pc)
//   imem_ack, imem_rdata           : response pulse and instruction word
//   ifid_valid, ifid_pc, ifid_instr: IF/ID register outputs
module fetch_stage #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 32,
    parameter int PC_INC  = fetch_pkg::PC_INC
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PC_W-1:0]    current_pc,
    output logic [PC_W-1:0]    next_pc,
    output logic               pc_write,
    input  logic               stall_id,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr
);
    import fetch_pkg::*;

    fetch_state_t       state;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    logic               ifid_load;
    logic               ifid_clear;
    logic [PC_W-1:0]    load_pc;
    logic [INSTR_W-1:0] load_instr;

    // Next-PC mux and IF/ID control. A redirect overrides everything else.
    always_comb begin
        imem_req   = (state != HOLD);
        imem_addr  = current_pc;
        pc_write   = 1'b0;
        next_pc    = current_pc + PC_W'(PC_INC);
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        load_pc    = current_pc;
        load_instr = imem_rdata;
        if (branch_taken) begin
            pc_write   = 1'b1;
            // Word-align the target by masking the two low bits.
            next_pc    = branch_target & ~PC_W'(3);
            ifid_clear = 1'b1;
        end else begin
            unique case (state)
                REQ: begin
                    if (imem_ack) begin
                        pc_write  = 1'b1;
                        ifid_load = !stall_id;
                    end else begin
                        // No word this cycle: insert a bubble unless decode is stalled.
                        ifid_clear = !stall_id;
                    end
                end
                HOLD: begin
                    if (!stall_id) begin
                        ifid_load  = 1'b1;
                        load_pc    = skid_pc;
                        load_instr = skid_instr;
                    end
                end
                DRAIN: ;
                default: ;
            endcase
        end
    end

    // Controller state and skid buffer. The skid is only meaningful in HOLD,
    // so its occupancy is implied by the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= REQ;
            skid_pc    <= '0;
            skid_instr <= INSTR_W'(NOP_INSTR);
        end else if (branch_taken) begin
            // A request still in flight (req high, no ack) owes one response
            // that belongs to the old path and must be swallowed.
            state      <= (state != HOLD && !imem_ack) ? DRAIN : REQ;
            skid_pc    <= '0;
            skid_instr <= INSTR_W'(NOP_INSTR);
        end else begin
            unique case (state)
                REQ: begin
                    if (imem_ack && stall_id) begin
                        skid_pc    <= current_pc;
                        skid_instr <= imem_rdata;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall_id) begin
                        skid_pc    <= '0;
                        skid_instr <= INSTR_W'(NOP_INSTR);
                        state      <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ack) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

    ifid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_ifid (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (ifid_load),
        .clear      (ifid_clear),
        .load_pc    (load_pc),
        .load_instr (load_instr),
        .valid      (ifid_valid),
        .pc         (ifid_pc),
        .instr      (ifid_instr)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch controller that sits between the program counter and the IF/ID boundary.
- Drives the PC's next_pc/PCWrite inputs and issues a req/ack handshake to instruction memory.
- Owns the IF/ID pipeline register, including a one-entry skid buffer for decode stalls.
- Applies branch redirects (flush) from the branch-resolution stage.

Parameters:
PC_W, 10, width of PC and instruction-memory byte address
INSTR_W, 32, instruction word width
PC_INC, 4, byte increment per sequential fetch

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
current_pc  input  PC_W  PC register output
next_pc  output  PC_W  value to load into PC (combinational)
pc_write  output  1  PC load enable (combinational)
stall_id  input  1  hazard unit: decode cannot accept; hold IF/ID
branch_taken  input  1  redirect/flush request (single-cycle pulse)
branch_target  input  PC_W  redirect address; bits [1:0] forced to 0
imem_req  output  1  fetch request
imem_addr  output  PC_W  fetch address (= current_pc)
imem_ack  input  1  data valid pulse; may arrive in the same cycle as req
imem_rdata  input  INSTR_W  instruction word, valid when imem_ack=1
ifid_valid  output  1  IF/ID holds a live instruction
ifid_pc  output  PC_W  PC of the IF/ID instruction
ifid_instr  output  INSTR_W  IF/ID instruction word

Behaviour:
Reset (reset_n=0, asynchronous):
- state=REQ; ifid_valid=0, ifid_pc=0, ifid_instr=0; skid buffer empty.
- imem_req is high in the first cycle after reset release.

Combinational outputs:
- imem_req=1 in REQ and DRAIN only.
- imem_addr=current_pc.
- pc_write=0 unless a rule below asserts it.
- next_pc=current_pc+PC_INC, modulo 2^PC_W (0x3FC wraps to 0x000).

REQ state:
- ack=0: hold req and addr. If stall_id=0, ifid_valid<=0 (bubble); if stall_id=1, IF/ID holds.
- ack=1, stall_id=0: IF/ID <= {1, current_pc, imem_rdata}; pc_write=1; stay in REQ.
- ack=1, stall_id=1: capture {current_pc, rdata} into skid; pc_write=1; go to HOLD. IF/ID holds.

HOLD state:
- No request is issued.
- While stall_id=1: IF/ID and skid hold.
- When stall_id=0: IF/ID <= skid contents with valid=1; skid is emptied; go to REQ.

DRAIN state (redirect with an unacked request outstanding):
- Keep req asserted at the redirected PC.
- Discard the next ack's data, then go to REQ.

Flush (branch_taken=1) has priority over stall_id and ack, in every state:
- pc_write=1; next_pc={branch_target[PC_W-1:2],2'b00}.
- ifid_valid<=0; skid is emptied.
- Next state: from REQ with ack=0, go to DRAIN (the memory still owes one response). From REQ with ack=1, discard the data and go to REQ. From HOLD, go to REQ. From DRAIN with ack=0, write the PC again and stay in DRAIN. From DRAIN with ack=1, go to REQ.

Invariants:
- At most one outstanding request.
- imem_addr is stable from req assertion until ack.
- pc_write is never asserted while stall_id=1 unless an ack or a flush occurs that cycle.

Decomposition:
- Package fetch_pkg: state enum {REQ, HOLD, DRAIN}; PC_INC; NOP_INSTR (32'h0) as the IF/ID reset/bubble value; IF/ID record typedef {valid, pc, instr}.
- Sub-module ifid_reg: IF/ID register with load, hold and clear inputs plus asynchronous active-low reset.
- The FSM, skid buffer and next-PC mux stay in fetch_stage.

Test Plan:
1. Zero-wait memory (ack tied to req), no stalls, PC starting at 0 → pc_write every cycle; ifid_pc sequence 0x000, 0x004, 0x008, …; ifid_valid=1 from the second cycle onward.
2. Ack delayed 2 cycles per fetch → imem_addr held constant; ifid_valid=0 for 2 cycles between instructions; pc_write only in ack cycles.
3. stall_id=1 for 3 cycles coinciding with an ack at PC 0x010 → go to HOLD, IF/ID unchanged; on release IF/ID gets {0x010, data}; next fetch at 0x014.
4. branch_taken with target 0x103 while a request is outstanding → pc_write=1, next_pc=0x100, ifid_valid=0; next ack is discarded; first valid IF/ID after that has pc=0x100.
5. branch_taken, stall_id and ack in the same cycle → flush wins: data dropped, no skid capture, PC=target, state REQ.
6. Reset asserted mid-DRAIN with a live IF/ID → all outputs go to reset values immediately; after release, a fetch is issued from current_pc=0.
